// File: rtl/sum_accumulator_pkg.sv
// Shared types and default sizing for the block-sum accumulator.
package sum_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_t;

    localparam int SUM_W_DEF   = 9;
    localparam int ACC_W_DEF   = 16;
    localparam int COUNT_N_DEF = 8;

endpackage

// File: rtl/sat_adder.sv
// Combinational unsigned adder that clamps to all-ones on carry-out.
module sat_adder #(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W:0] full;

    // One extra bit catches the carry that marks an overflow.
    assign full = {1'b0, a} + {1'b0, b};
    assign ovf  = full[ACC_W];
    assign sum  = ovf ? {ACC_W{1'b1}} : full[ACC_W-1:0];

endmodule

// File: rtl/sum_accumulator.sv
// Sums COUNT_N unsigned samples into a saturating block total, then holds
// the result until the downstream handshake takes it.
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int SUM_W   = SUM_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int COUNT_N = COUNT_N_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [SUM_W-1:0] in_sum,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_sat,
    output logic [7:0]       sample_cnt
);

    localparam logic [7:0] CNT_LAST = 8'(COUNT_N);

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic             sat;
    logic             ovf;
    logic [7:0]       cnt_nxt;

    sat_adder #(.ACC_W(ACC_W)) u_add (
        .a   (acc),
        .b   ({{(ACC_W-SUM_W){1'b0}}, in_sum}),
        .sum (acc_nxt),
        .ovf (ovf)
    );

    assign cnt_nxt = sample_cnt + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ACCUM;
            acc        <= '0;
            sat        <= 1'b0;
            sample_cnt <= 8'd0;
        end else if (clear) begin
            // Abort wins over both a concurrent accept and a handshake.
            state      <= ACCUM;
            acc        <= '0;
            sat        <= 1'b0;
            sample_cnt <= 8'd0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        acc        <= acc_nxt;
                        sat        <= sat | ovf;
                        sample_cnt <= cnt_nxt;
                        if (cnt_nxt == CNT_LAST)
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state      <= ACCUM;
                        acc        <= '0;
                        sat        <= 1'b0;
                        sample_cnt <= 8'd0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign out_acc   = acc;
    assign out_sat   = sat;

endmodule

// File: tb/tb_sum_accumulator.sv
// Four instances (COUNT_N = 8, 4, 1, 255) checked every cycle against a
// block-total model, plus directed scenarios for the documented corner cases.
module tb_sum_accumulator;

    localparam int ND   = 4;
    localparam int SW   = 9;
    localparam int AW   = 16;
    localparam longint AMAX = 65535;

    function automatic int cn_of(input int i);
        case (i)
            0:       return 8;
            1:       return 4;
            2:       return 1;
            default: return 255;
        endcase
    endfunction

    logic                     clk = 1'b0;
    logic                     reset;
    logic [ND-1:0]            clear;
    logic [ND-1:0]            in_valid;
    logic [ND-1:0][SW-1:0]    in_sum;
    logic [ND-1:0]            in_ready;
    logic [ND-1:0]            out_valid;
    logic [ND-1:0]            out_ready;
    logic [ND-1:0][AW-1:0]    out_acc;
    logic [ND-1:0]            out_sat;
    logic [ND-1:0][7:0]       sample_cnt;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        sum_accumulator #(.SUM_W(SW), .ACC_W(AW), .COUNT_N(cn_of(g))) dut (
            .clk        (clk),
            .reset      (reset),
            .clear      (clear[g]),
            .in_valid   (in_valid[g]),
            .in_sum     (in_sum[g]),
            .in_ready   (in_ready[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_acc    (out_acc[g]),
            .out_sat    (out_sat[g]),
            .sample_cnt (sample_cnt[g])
        );
    end

    // Model: unbounded running total of the current block, its sample count,
    // and whether the block is complete and waiting to be taken.
    longint tot  [ND];
    int     cnt  [ND];
    bit     done [ND];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_zero(input int i);
        tot[i]  = 0;
        cnt[i]  = 0;
        done[i] = 1'b0;
    endtask

    task automatic check_all();
        for (int i = 0; i < ND; i++) begin
            longint ea;
            ea = (tot[i] > AMAX) ? AMAX : tot[i];
            check($sformatf("dut%0d_in_ready", i),  32'(in_ready[i]),   32'(!done[i]));
            check($sformatf("dut%0d_out_valid", i), 32'(out_valid[i]),  32'(done[i]));
            check($sformatf("dut%0d_out_acc", i),   32'(out_acc[i]),    32'(ea));
            check($sformatf("dut%0d_out_sat", i),   32'(out_sat[i]),    32'(tot[i] > AMAX));
            check($sformatf("dut%0d_sample_cnt", i), 32'(sample_cnt[i]), 32'(cnt[i]));
        end
    endtask

    // Inputs captured before the edge, model advanced after, then all checked.
    task automatic tick();
        logic [ND-1:0]         v, c, r;
        logic [ND-1:0][SW-1:0] s;
        v = in_valid; c = clear; r = out_ready; s = in_sum;
        @(posedge clk);
        #1;
        for (int i = 0; i < ND; i++) begin
            if (reset || c[i]) model_zero(i);
            else if (done[i]) begin
                if (r[i]) model_zero(i);
            end else if (v[i]) begin
                tot[i] += longint'(s[i]);
                cnt[i]++;
                if (cnt[i] == cn_of(i)) done[i] = 1'b1;
            end
        end
        check_all();
    endtask

    initial begin
        reset     = 1'b1;
        clear     = '0;
        in_valid  = '0;
        in_sum    = '0;
        out_ready = '1;
        for (int i = 0; i < ND; i++) model_zero(i);

        // Reset state while held
        #12;
        check_all();
        tick();
        reset = 1'b0;
        tick();

        // COUNT_N=4: 1,2,3,4 back-to-back
        for (int k = 1; k <= 4; k++) begin
            in_valid[1] = 1'b1;
            in_sum[1]   = 9'(k);
            tick();
        end
        in_valid[1] = 1'b0;
        check("r030_valid", 32'(out_valid[1]), 32'd1);
        check("r030_acc",   32'(out_acc[1]),   32'd10);
        check("r030_sat",   32'(out_sat[1]),   32'd0);
        tick();
        check("r030_ready_after", 32'(in_ready[1]), 32'd1);

        // COUNT_N=255: 255 x 511 saturates
        in_valid[3] = 1'b1;
        in_sum[3]   = 9'd511;
        for (int k = 0; k < 255; k++) tick();
        in_valid[3] = 1'b0;
        check("r031_acc", 32'(out_acc[3]), 32'd65535);
        check("r031_sat", 32'(out_sat[3]), 32'd1);
        tick();

        // COUNT_N=8: 8 x 3 under 5 cycles of backpressure
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_sum[0]    = 9'd3;
        for (int k = 0; k < 8; k++) tick();
        for (int k = 0; k < 5; k++) begin
            in_valid[0] = 1'($urandom_range(0, 1));
            in_sum[0]   = 9'($urandom_range(0, 511));
            check("r032_valid_held", 32'(out_valid[0]), 32'd1);
            check("r032_acc_stable", 32'(out_acc[0]),   32'd24);
            check("r032_ready_low",  32'(in_ready[0]),  32'd0);
            tick();
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        check("r032_cleared", 32'(out_acc[0]), 32'd0);

        // Clear mid-block, concurrent with a sample
        in_valid[0] = 1'b1;
        in_sum[0]   = 9'd10;
        for (int k = 0; k < 3; k++) tick();
        clear[0] = 1'b1;
        tick();
        clear[0] = 1'b0;
        check("r033_cnt", 32'(sample_cnt[0]), 32'd0);
        check("r033_acc", 32'(out_acc[0]),    32'd0);
        in_sum[0] = 9'd1;
        for (int k = 0; k < 8; k++) tick();
        in_valid[0] = 1'b0;
        check("r033_acc8", 32'(out_acc[0]), 32'd8);
        tick();

        // COUNT_N=1: 7 then 9 with in_valid held
        in_valid[2] = 1'b1;
        in_sum[2]   = 9'd7;
        tick();
        check("r035_first", 32'(out_acc[2]), 32'd7);
        check("r035_rdy_lo1", 32'(in_ready[2]), 32'd0);
        in_sum[2] = 9'd9;
        tick();
        check("r035_rdy_hi", 32'(in_ready[2]), 32'd1);
        tick();
        in_valid[2] = 1'b0;
        check("r035_second", 32'(out_acc[2]), 32'd9);
        check("r035_rdy_lo2", 32'(in_ready[2]), 32'd0);
        tick();

        // Randomized traffic on all instances
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < ND; i++) begin
                in_valid[i]  = ($urandom_range(0, 3) != 0);
                in_sum[i]    = 9'($urandom_range(0, 511));
                out_ready[i] = ($urandom_range(0, 2) != 0);
                clear[i]     = ($urandom_range(0, 39) == 0);
            end
            tick();
        end
        in_valid  = '0;
        out_ready = '1;
        clear     = '1;
        tick();
        clear = '0;

        // Async reset: dut0 mid-block at 5, dut1 pending with 40
        out_ready[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid[0] = 1'b1;
            in_sum[0]   = 9'd7;
            in_valid[1] = (k < 4);
            in_sum[1]   = 9'd10;
            tick();
        end
        in_valid = '0;
        check("r034_cnt5",  32'(sample_cnt[0]), 32'd5);
        check("r034_acc40", 32'(out_acc[1]),    32'd40);
        check("r034_done",  32'(out_valid[1]),  32'd1);
        #2;
        reset = 1'b1;
        #2;
        for (int i = 0; i < ND; i++) model_zero(i);
        check("r034_async_valid", 32'(out_valid[1]), 32'd0);
        check("r034_async_acc",   32'(out_acc[0]),   32'd0);
        check_all();
        tick();
        reset        = 1'b0;
        out_ready[1] = 1'b1;
        in_valid[0]  = 1'b1;
        in_sum[0]    = 9'd2;
        tick();
        in_valid[0] = 1'b0;
        check("r034_new_block", 32'(sample_cnt[0]), 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have parameter SUM_W, default 9, input sample width (matches adder sum).
REQ-002 SHALL have parameter ACC_W, default 16, accumulator/result width; legal range ACC_W > SUM_W.
REQ-003 SHALL have parameter COUNT_N, default 8, samples per block; legal range 1..255.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clear  input  1  synchronous abort of current block.
REQ-007 SHALL have port in_valid  input  1  upstream sample valid.
REQ-008 SHALL have port in_sum  input  SUM_W  unsigned sample.
REQ-009 SHALL have port in_ready  output  1  block accepts sample this cycle.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port out_acc  output  ACC_W  block sum, saturated.
REQ-013 SHALL have port out_sat  output  1  saturation occurred in this block.
REQ-014 SHALL have port sample_cnt  output  8  samples accepted in current block.

Function
REQ-015 SHALL implement FSM with states ACCUM and DONE.
REQ-016 ACCUM: in_ready=1, out_valid=0; DONE: in_ready=0, out_valid=1; both outputs registered-state decodes, no combinational path from in_valid/out_ready.
REQ-017 Input accept = in_valid && in_ready; on accept, acc <= acc + zero-extended in_sum, sample_cnt <= sample_cnt + 1.
REQ-018 Addition SHALL be computed at ACC_W+1 bits; if result > 2^ACC_W-1, acc SHALL saturate to 2^ACC_W-1 and sat flag SHALL set (sticky until block ends).
REQ-019 Accept making sample_cnt reach COUNT_N SHALL move FSM to DONE; out_valid asserted the next cycle (latency 1 cycle after final accept).
REQ-020 out_acc and out_sat SHALL reflect acc and sat flag continuously; stable throughout DONE.
REQ-021 Output handshake = out_valid && out_ready; on it acc, sat, sample_cnt SHALL clear to 0 and FSM return to ACCUM; in_ready high the following cycle.
REQ-022 out_valid held indefinitely in DONE while out_ready=0 (backpressure); no samples accepted in DONE.
REQ-023 clear=1 SHALL, in any state, zero acc, sat, sample_cnt and force ACCUM next cycle; clear has priority over concurrent input accept and output handshake (sample dropped, result discarded).
REQ-024 in_sum ignored when no accept occurs.
REQ-025 COUNT_N=1: every accept moves directly to DONE.

Reset
REQ-026 reset=1 SHALL asynchronously force ACCUM, acc=0, sat=0, sample_cnt=0; hence in_ready=1, out_valid=0, out_acc=0, out_sat=0 while held.
REQ-027 Reset mid-block or mid-DONE SHALL discard partial/pending result; first accept after reset release starts a new block.

Structure
REQ-028 Shared package SHALL hold FSM state typedef (ACCUM, DONE) and default constants SUM_W_DEF=9, ACC_W_DEF=16, COUNT_N_DEF=8.
REQ-029 One sub-module natural: sat_adder (parameterized ACC_W saturating adder, combinational, outputs sum and overflow flag); FSM and counters stay in sum_accumulator.

Verification
REQ-030 COUNT_N=4, samples 1,2,3,4 back-to-back, out_ready=1 -> out_valid one cycle after 4th accept, out_acc=10, out_sat=0, then in_ready=1 next cycle.
REQ-031 COUNT_N=255, 255 samples of 511 -> out_acc=65535, out_sat=1 (unsaturated total 130305).
REQ-032 Block of 8x value 3 with out_ready=0 for 5 cycles -> out_valid held 5 cycles, out_acc=24 stable, in_ready=0, in_valid pulses ignored; handshake on cycle 6 clears.
REQ-033 3 samples of 10 then clear=1 concurrent with in_valid=1 -> sample_cnt=0, acc=0 next cycle; next 8 samples of 1 -> out_acc=8.
REQ-034 reset asserted mid-block (sample_cnt=5) and asynchronously between edges -> outputs zero immediately; in DONE with out_acc=40 -> out_valid drops immediately.
REQ-035 COUNT_N=1, samples 7 then 9 with out_ready=1 -> two results 7 and 9, in_ready low exactly one cycle each.
